// File: rtl/lru_cache_pkg.sv
// Shared defaults for the fully associative LRU cache and its age tracker.
package lru_cache_pkg;
  localparam int NUM_LINES_DEF   = 4;
  localparam int TAG_WIDTH_DEF   = 4;
  localparam int VALUE_WIDTH_DEF = 32;
  localparam int AGE_W_DEF       = $clog2(NUM_LINES_DEF);
endpackage

// File: rtl/lru_cache_age.sv
// Per-line age counters: 0 is most recently used, NUM_LINES-1 is the LRU line.
// Also picks the victim line for an allocating write.
module lru_age_tracker #(
  parameter int NUM_LINES = 4,
  parameter int AW        = $clog2(NUM_LINES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_i,
  input  logic [AW-1:0]        upd_idx_i,
  input  logic [NUM_LINES-1:0] valid_i,
  output logic [AW-1:0]        victim_o
);
  logic [NUM_LINES-1:0][AW-1:0] age_q, age_d;
  logic [AW-1:0]                old_age;

  always_comb begin
    age_d   = age_q;
    old_age = age_q[upd_idx_i];
    if (upd_i) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (AW'(i) == upd_idx_i)
          age_d[i] = '0;
        else if (age_q[i] < old_age)
          age_d[i] = age_q[i] + AW'(1);
      end
    end
  end

  // Invalid lines win over the LRU line; the descending scan leaves the lowest invalid index.
  always_comb begin
    victim_o = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (age_q[i] == AW'(NUM_LINES - 1)) victim_o = AW'(i);
    for (int i = NUM_LINES - 1; i >= 0; i--)
      if (!valid_i[i]) victim_o = AW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) age_q[i] <= AW'(i);
    end else begin
      age_q <= age_d;
    end
  end
endmodule

// File: rtl/lru_cache.sv
// Fully associative write-back cache with true LRU replacement.
// Outputs are registered and describe the operation sampled on the previous edge.
module lru_cache
  import lru_cache_pkg::*;
#(
  parameter int NUM_LINES   = NUM_LINES_DEF,
  parameter int TAG_WIDTH   = TAG_WIDTH_DEF,
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   select,
  input  logic [TAG_WIDTH-1:0]   input_tag,
  input  logic [VALUE_WIDTH-1:0] new_value,
  input  logic                   RD_,
  input  logic                   WR_,
  input  logic                   is_new,
  output logic                   cache_miss,
  output logic                   memwrite,
  output logic [TAG_WIDTH-1:0]   tag_write,
  output logic [VALUE_WIDTH-1:0] value_write
);
  localparam int AW = $clog2(NUM_LINES);

  logic [NUM_LINES-1:0]                  valid_q, valid_d, dirty_q, dirty_d;
  logic [NUM_LINES-1:0][TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [NUM_LINES-1:0][VALUE_WIDTH-1:0] val_q, val_d;

  logic                   miss_q, miss_d, mw_q, mw_d;
  logic [TAG_WIDTH-1:0]   tw_q, tw_d;
  logic [VALUE_WIDTH-1:0] vw_q, vw_d;

  logic          op_wr, op_rd, hit;
  logic [AW-1:0] hit_idx, victim;

  assign op_wr = select && !WR_;
  assign op_rd = select && WR_ && !RD_;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && tag_q[i] == input_tag) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end

  lru_age_tracker #(.NUM_LINES(NUM_LINES), .AW(AW)) u_age (
    .clk       (clk),
    .rst       (rst),
    .upd_i     ((op_rd && hit) || op_wr),
    .upd_idx_i (hit ? hit_idx : victim),
    .valid_i   (valid_q),
    .victim_o  (victim)
  );

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    val_d   = val_q;
    if (op_wr) begin
      if (hit) begin
        val_d[hit_idx] = new_value;
        if (!is_new) dirty_d[hit_idx] = 1'b1;
      end else begin
        valid_d[victim] = 1'b1;
        dirty_d[victim] = !is_new;
        tag_d[victim]   = input_tag;
        val_d[victim]   = new_value;
      end
    end
  end

  // tag_write/value_write only move on a read hit or a dirty eviction.
  always_comb begin
    miss_d = 1'b0;
    mw_d   = 1'b0;
    tw_d   = tw_q;
    vw_d   = vw_q;
    if (op_rd) begin
      if (hit) begin
        tw_d = input_tag;
        vw_d = val_q[hit_idx];
      end else begin
        miss_d = 1'b1;
      end
    end else if (op_wr && !hit) begin
      miss_d = 1'b1;
      if (valid_q[victim] && dirty_q[victim]) begin
        mw_d = 1'b1;
        tw_d = tag_q[victim];
        vw_d = val_q[victim];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '0;
      val_q   <= '0;
      miss_q  <= 1'b0;
      mw_q    <= 1'b0;
      tw_q    <= '0;
      vw_q    <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      val_q   <= val_d;
      miss_q  <= miss_d;
      mw_q    <= mw_d;
      tw_q    <= tw_d;
      vw_q    <= vw_d;
    end
  end

  assign cache_miss  = miss_q;
  assign memwrite    = mw_q;
  assign tag_write   = tw_q;
  assign value_write = vw_q;
endmodule

// File: tb/tb_lru_cache.sv
// Directed plus random stimulus against a move-to-front recency-list model of the cache.
module tb_lru_cache;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int VW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          select = 1'b0;
  logic [TW-1:0] input_tag = '0;
  logic [VW-1:0] new_value = '0;
  logic          RD_ = 1'b1;
  logic          WR_ = 1'b1;
  logic          is_new = 1'b0;
  logic          cache_miss, memwrite;
  logic [TW-1:0] tag_write;
  logic [VW-1:0] value_write;

  lru_cache #(.NUM_LINES(N), .TAG_WIDTH(TW), .VALUE_WIDTH(VW)) dut (
    .clk(clk), .rst(rst), .select(select), .input_tag(input_tag),
    .new_value(new_value), .RD_(RD_), .WR_(WR_), .is_new(is_new),
    .cache_miss(cache_miss), .memwrite(memwrite),
    .tag_write(tag_write), .value_write(value_write)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: per-line contents plus a recency list (order[0] = most recent line).
  bit          m_valid [N];
  bit          m_dirty [N];
  int          m_tag   [N];
  logic [VW-1:0] m_val [N];
  int          order   [N];
  bit          e_miss, e_mw;
  logic [TW-1:0] e_tw;
  logic [VW-1:0] e_vw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; m_val[i] = '0; order[i] = i;
    end
    e_miss = 0; e_mw = 0; e_tw = '0; e_vw = '0;
  endfunction

  function automatic void touch(input int line);
    int p = 0;
    for (int i = 0; i < N; i++) if (order[i] == line) p = i;
    for (int i = p; i > 0; i--) order[i] = order[i-1];
    order[0] = line;
  endfunction

  function automatic void m_step(input bit r, s, rdn, wrn, isn, input int t, input logic [VW-1:0] v);
    int h = -1;
    int vic = -1;
    e_miss = 0; e_mw = 0;
    if (r) begin m_reset(); return; end
    for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == t) h = i;
    if (s && !wrn) begin
      if (h >= 0) begin
        m_val[h] = v;
        if (!isn) m_dirty[h] = 1;
        touch(h);
      end else begin
        for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) vic = i;
        if (vic < 0) vic = order[N-1];
        e_miss = 1;
        if (m_valid[vic] && m_dirty[vic]) begin
          e_mw = 1; e_tw = TW'(m_tag[vic]); e_vw = m_val[vic];
        end
        m_valid[vic] = 1; m_dirty[vic] = !isn; m_tag[vic] = t; m_val[vic] = v;
        touch(vic);
      end
    end else if (s && !rdn) begin
      if (h >= 0) begin
        e_tw = TW'(t); e_vw = m_val[h];
        touch(h);
      end else begin
        e_miss = 1;
      end
    end
  endfunction

  task automatic apply(input bit r, s, rdn, wrn, isn, input int t, input logic [VW-1:0] v);
    rst = r; select = s; RD_ = rdn; WR_ = wrn; is_new = isn;
    input_tag = TW'(t); new_value = v;
    @(posedge clk);
    m_step(r, s, rdn, wrn, isn, t, v);
    #1;
    chk("cache_miss", 64'(cache_miss), 64'(e_miss));
    chk("memwrite", 64'(memwrite), 64'(e_mw));
    chk("tag_write", 64'(tag_write), 64'(e_tw));
    chk("value_write", 64'(value_write), 64'(e_vw));
  endtask

  task automatic wr(input int t, input bit isn);
    apply(0, 1, 1, 0, isn, t, 32'hA000_0000 + 32'(t));
  endtask

  task automatic rd(input int t);
    apply(0, 1, 0, 1, 0, t, 32'h0);
  endtask

  initial begin
    m_reset();
    apply(1, 0, 1, 1, 0, 0, 32'h0);
    chk("reset_tag_write", 64'(tag_write), 64'h0);
    for (int t = 5; t <= 8; t++) wr(t, 0);
    wr(9, 0);
    chk("evict5_tag", 64'(tag_write), 64'd5);
    chk("evict5_val", 64'(value_write), 64'hA000_0005);
    wr(10, 0);
    chk("evict6_tag", 64'(tag_write), 64'd6);
    wr(11, 0);
    chk("evict7_tag", 64'(tag_write), 64'd7);
    for (int t = 9; t <= 11; t++) rd(t);
    chk("read11_val", 64'(value_write), 64'hA000_000B);
    rd(13);
    chk("read13_miss", 64'(cache_miss), 64'd1);
    wr(13, 1);
    chk("evict8_mw", 64'(memwrite), 64'd1);
    chk("evict8_tag", 64'(tag_write), 64'd8);
    for (int t = 1; t <= 3; t++) wr(t, 0);
    wr(4, 0);
    chk("evict13_clean", 64'(memwrite), 64'd0);
    apply(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    rd(1);
    chk("read1_after_idle", 64'(value_write), 64'hA000_0001);
    apply(1, 1, 0, 0, 0, 2, 32'h1234_5678);
    rd(9);
    rd(4);
    chk("read4_after_rst", 64'(cache_miss), 64'd1);

    for (int k = 0; k < 1500; k++) begin
      bit r   = ($urandom_range(0, 99) == 0);
      bit s   = ($urandom_range(0, 9) != 0);
      bit rdn = $urandom_range(0, 1) == 1;
      bit wrn = $urandom_range(0, 1) == 1;
      bit isn = $urandom_range(0, 1) == 1;
      apply(r, s, rdn, wrn, isn, int'($urandom_range(0, 7)), 32'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
